// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipeline: default widths, opcode map
// and the fetch-stage state encoding.
package core_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_LW   = 4'h4;
  localparam logic [3:0] OPC_SW   = 4'h5;
  localparam logic [3:0] OPC_BEQ  = 4'h6;
  localparam logic [3:0] OPC_JMP  = 4'h7;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard/branch inputs from ID, instruction memory
// port, and the IF/ID register view seen by decode.
interface fetch_stage_if
  import core_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               stall;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc2;
  logic               if_id_valid;
  logic               halted;

  modport master (
    input  stall, br_taken, br_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
  );

  modport slave (
    output stall, br_taken, br_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold beats squash beats load; squash only
// clears valid so decode still sees the last instruction's fields.
module if_id_reg
  import core_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  input  logic               squash_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc2_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc2_o,
  output logic               valid_o
);
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc2_q, pc2_d;
  logic               valid_q, valid_d;

  // next-state selection for the register fields
  always_comb begin
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (hold_i) begin
      valid_d = valid_q;
    end else if (squash_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc2_d   = pc2_i;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= {INSTR_W{1'b0}};
      pc2_q   <= {PC_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc2_o   = pc2_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, HALT drain FSM and the
// IF/ID register instance.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter int              INSTR_W      = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
  parameter logic [3:0]      HALT_OPC     = OPC_HALT,
  parameter int              DRAIN_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic             hold_s, squash_s, load_s, is_halt_s;
  logic [PC_W-1:0]  pc_plus2_s;

  assign pc_plus2_s = pc_q + PC_W'(2);
  assign is_halt_s  = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPC);

  // next-PC mux, halt FSM and IF/ID control
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    hold_s   = 1'b0;
    squash_s = 1'b0;
    load_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.stall) begin
          hold_s = 1'b1;
        end else if (bus.br_taken) begin
          pc_d     = bus.br_target & ~{{(PC_W-1){1'b0}}, 1'b1};
          squash_s = 1'b1;
        end else if (is_halt_s) begin
          load_s  = 1'b1;
          state_d = ST_HALT_PEND;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          load_s = 1'b1;
          pc_d   = pc_plus2_s;
        end
      end
      ST_HALT_PEND: begin
        squash_s = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = ST_HALT_PEND;
        end
      end
      ST_HALTED: begin
        squash_s = 1'b1;
        halted_d = 1'b1;
      end
      default: begin
        // an illegal encoding parks the core rather than fetching garbage
        squash_s = 1'b1;
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end
    endcase
  end

  // PC, FSM, drain counter and halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_RUN;
      cnt_q    <= {CNT_W{1'b0}};
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold_i   (hold_s),
    .squash_i (squash_s),
    .load_i   (load_s),
    .instr_i  (bus.imem_rdata),
    .pc2_i    (pc_plus2_s),
    .instr_o  (bus.if_id_instr),
    .pc2_o    (bus.if_id_pc2),
    .valid_o  (bus.if_id_valid)
  );

  assign bus.imem_addr = pc_q;
  assign bus.halted    = halted_q;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage 16-bit pipeline. Holds the PC, drives instruction-memory address, and owns the IF/ID pipeline register.
- Consumes the ID-stage hazard stall and the ID-stage branch resolution (taken/target).
- Feeds the IF/ID register to decode. Detects HALT, drains the pipeline, then raises a sticky halted flag.

Parameters:
- PC_W, 16, PC and address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- HALT_OPC, 4'hF, opcode (instr[15:12]) that means HALT.
- DRAIN_CYCLES, 4, cycles spent in HALT_PEND before halted asserts; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  ID hazard stall; freezes PC and IF/ID.
- br_taken  in  1  branch in ID resolved taken this cycle.
- br_target  in  PC_W  redirect address; bit 0 ignored (forced 0).
- imem_addr  out  PC_W  equals current PC, combinational from the PC register.
- imem_rdata  in  INSTR_W  instruction at imem_addr, same-cycle read.
- if_id_instr  out  INSTR_W  registered instruction to decode.
- if_id_pc2  out  PC_W  registered PC+2 of that instruction.
- if_id_valid  out  1  0 = bubble; decode treats it as a NOP.
- halted  out  1  sticky; core has stopped fetching and has drained.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, if_id_instr=0, if_id_pc2=0, if_id_valid=0, halted=0.
  - State RUN, drain counter 0.
- State RUN, per rising edge, priority stall > br_taken > halt > normal:
  - stall=1:
    - PC and all IF/ID fields hold; state holds.
    - br_taken is ignored, because the branch is not yet resolved while stalled.
  - br_taken=1, stall=0:
    - PC <= {br_target[PC_W-1:1],1'b0}.
    - if_id_valid <= 0 (squash the wrong-path fetch).
    - A HALT fetched this cycle is squashed and does not enter HALT_PEND.
  - Fetched opcode == HALT_OPC, no stall, no br_taken:
    - IF/ID latches the HALT with valid=1 and pc2=PC+2.
    - PC holds.
    - State -> HALT_PEND, counter <= 0.
  - Normal:
    - PC <= PC+2, modulo 2^PC_W (0xFFFE -> 0x0000).
    - if_id_instr <= imem_rdata, if_id_pc2 <= PC+2, if_id_valid <= 1.
- State HALT_PEND:
  - PC holds; if_id_valid <= 0 each cycle (bubbles); instr and pc2 hold.
  - stall and br_taken are ignored. Branches resolve in ID, so nothing older can redirect.
  - Counter increments each cycle.
  - When counter == DRAIN_CYCLES-1: state -> HALTED, halted <= 1 on that same edge.
  - Result: halted rises exactly DRAIN_CYCLES edges after the HALT enters IF/ID.
- State HALTED:
  - Terminal; halted stays 1, PC frozen, if_id_valid=0.
  - Exits only via rst_n.
- Reset asserted mid-operation (any state, including HALT_PEND mid-count) returns every output to its reset value immediately; no partial state survives.
- Latency:
  - Normal instruction appears on IF/ID one edge after its address is on imem_addr.
  - Redirect target appears on imem_addr one edge after br_taken.

Decomposition:
- Shared package (core_pkg):
  - fetch-state enum {RUN, HALT_PEND, HALTED};
  - HALT_OPC and the opcode constants shared with decode and hazard logic;
  - PC_W and INSTR_W defaults.
- One natural sub-module, if_id_reg: the IF/ID register.
  - Inputs: async reset, hold (stall), squash (valid<=0), load.
- fetch_stage keeps the PC register, next-PC mux, halt FSM and drain counter.

Test Plan:
- Reset then 3 free-running cycles, imem returns 16'h1234/5678/9ABC -> imem_addr 0,2,4,6; IF/ID shows 1234/pc2=2/valid=1, then 5678/pc2=4, then 9ABC/pc2=6.
- stall=1 for 2 cycles while PC=0x0006 -> imem_addr stays 0x0006; IF/ID unchanged; br_taken=1 with target 0x0040 during stall has no effect.
- br_taken=1, stall=0, br_target=0x0041 at PC=0x0008 -> next imem_addr=0x0040; if_id_valid=0 that edge; next edge fetches from 0x0040 with valid=1.
- HALT (16'hF000) fetched at 0x0010, DRAIN_CYCLES=4 -> IF/ID=F000 valid=1; PC stays 0x0010; 3 bubble edges, then halted=1 on the 4th edge after latch; halted stays 1 with further clocks.
- HALT fetched in the same cycle br_taken=1 (target 0x0020) -> HALT squashed; state stays RUN; fetching continues at 0x0020; halted=0.
- PC=0xFFFE, normal cycle -> imem_addr wraps to 0x0000; if_id_pc2=0x0000. Then rst_n=0 mid-HALT_PEND (counter=2) -> all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC.
